// File: rtl/stall_aware_producer.sv
// rtl/stall_aware_producer.sv - two-lane stall-aware word producer with periodic per-lane flushes

// One independent producer lane: IDLE / SEND / FLUSH
module stall_aware_producer_lane #(
   parameter int                DATA_W       = 32,
   parameter logic [DATA_W-1:0] SEED         = '0,
   parameter int                STEP         = 1,
   parameter int                FLUSH_PERIOD = 16,
   parameter int                FLUSH_LEN    = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              stall,
   output logic [DATA_W-1:0] data,
   output logic              valid,
   output logic              flush,
   output logic [15:0]       sent_count
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SEND  = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;

   // Counter widths stay at least one bit even for degenerate parameter values
   localparam int FC_W = (FLUSH_PERIOD > 1) ? $clog2(FLUSH_PERIOD + 1) : 1;
   localparam int FL_W = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

   localparam logic [FC_W-1:0]   FC_LAST = FC_W'(FLUSH_PERIOD - 1);
   localparam logic [FL_W-1:0]   FL_INIT = FL_W'(FLUSH_LEN - 1);
   localparam logic [DATA_W-1:0] STEP_W  = DATA_W'(STEP);

   logic [1:0]        state_q;
   logic [DATA_W-1:0] data_q;
   logic              valid_q;
   logic              flush_q;
   logic [15:0]       count_q;
   logic [FC_W-1:0]   fcnt_q;
   logic [FL_W-1:0]   flen_q;

   // Lane state machine; valid/flush are registered alongside the state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         data_q  <= SEED;
         valid_q <= 1'b0;
         flush_q <= 1'b0;
         count_q <= 16'd0;
         fcnt_q  <= '0;
         flen_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (enable) begin
                  state_q <= S_SEND;
                  valid_q <= 1'b1;
               end
            end
            S_SEND: begin
               // Without acceptance the word is held, even if enable drops
               if (!stall) begin
                  data_q  <= data_q + STEP_W;
                  count_q <= count_q + 16'd1;
                  if (FLUSH_PERIOD != 0 && fcnt_q == FC_LAST) begin
                     state_q <= S_FLUSH;
                     fcnt_q  <= '0;
                     valid_q <= 1'b0;
                     flush_q <= 1'b1;
                     flen_q  <= FL_INIT;
                  end else begin
                     if (FLUSH_PERIOD != 0) begin
                        fcnt_q <= fcnt_q + 1'b1;
                     end
                     if (!enable) begin
                        state_q <= S_IDLE;
                        valid_q <= 1'b0;
                     end
                  end
               end
            end
            S_FLUSH: begin
               // Flush length is fixed; stall has no effect while invalid
               if (flen_q == '0) begin
                  flush_q <= 1'b0;
                  if (enable) begin
                     state_q <= S_SEND;
                     valid_q <= 1'b1;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end else begin
                  flen_q <= flen_q - 1'b1;
               end
            end
            default: begin
               state_q <= S_IDLE;
               valid_q <= 1'b0;
               flush_q <= 1'b0;
            end
         endcase
      end
   end

   assign data       = data_q;
   assign valid      = valid_q;
   assign flush      = flush_q;
   assign sent_count = count_q;

endmodule

// Two lanes with no cross-lane coupling
module stall_aware_producer #(
   parameter int                DATA_W       = 32,
   parameter logic [DATA_W-1:0] SEED_1       = 32'h0000_0001,
   parameter logic [DATA_W-1:0] SEED_2       = 32'h0001_0000,
   parameter int                STEP         = 1,
   parameter int                FLUSH_PERIOD = 16,
   parameter int                FLUSH_LEN    = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              stall_1,
   input  logic              stall_2,
   output logic [DATA_W-1:0] pipeline1_inputs,
   output logic [DATA_W-1:0] pipeline2_inputs,
   output logic [1:0]        in_valid,
   output logic              flush_1,
   output logic              flush_2,
   output logic [15:0]       sent_count_1,
   output logic [15:0]       sent_count_2
);

   logic valid_1;
   logic valid_2;

   stall_aware_producer_lane #(
      .DATA_W(DATA_W), .SEED(SEED_1), .STEP(STEP),
      .FLUSH_PERIOD(FLUSH_PERIOD), .FLUSH_LEN(FLUSH_LEN)
   ) u_lane1 (
      .clk(clk), .rst_n(reset), .enable(enable), .stall(stall_1),
      .data(pipeline1_inputs), .valid(valid_1), .flush(flush_1),
      .sent_count(sent_count_1)
   );

   stall_aware_producer_lane #(
      .DATA_W(DATA_W), .SEED(SEED_2), .STEP(STEP),
      .FLUSH_PERIOD(FLUSH_PERIOD), .FLUSH_LEN(FLUSH_LEN)
   ) u_lane2 (
      .clk(clk), .rst_n(reset), .enable(enable), .stall(stall_2),
      .data(pipeline2_inputs), .valid(valid_2), .flush(flush_2),
      .sent_count(sent_count_2)
   );

   assign in_valid = {valid_2, valid_1};

endmodule

// File: tb/tb_stall_aware_producer.sv
// tb/tb_stall_aware_producer.sv - directed self-checking bench for stall_aware_producer

module tb_stall_aware_producer;

   logic        clk;
   logic        reset;
   logic        enable;
   logic        stall_1;
   logic        stall_2;
   logic [31:0] pipeline1_inputs;
   logic [31:0] pipeline2_inputs;
   logic [1:0]  in_valid;
   logic        flush_1;
   logic        flush_2;
   logic [15:0] sent_count_1;
   logic [15:0] sent_count_2;

   int errors = 0;
   int checks = 0;

   stall_aware_producer dut (
      .clk(clk), .reset(reset), .enable(enable),
      .stall_1(stall_1), .stall_2(stall_2),
      .pipeline1_inputs(pipeline1_inputs), .pipeline2_inputs(pipeline2_inputs),
      .in_valid(in_valid), .flush_1(flush_1), .flush_2(flush_2),
      .sent_count_1(sent_count_1), .sent_count_2(sent_count_2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset   = 1'b0;
      enable  = 1'b0;
      stall_1 = 1'b0;
      stall_2 = 1'b0;
      repeat (3) tick();
      check("rst_data1", pipeline1_inputs, 32'h1);
      check("rst_data2", pipeline2_inputs, 32'h10000);
      check("rst_valid", {30'd0, in_valid}, 32'd0);
      check("rst_flush1", {31'd0, flush_1}, 32'd0);
      check("rst_flush2", {31'd0, flush_2}, 32'd0);
      check("rst_cnt1", {16'd0, sent_count_1}, 32'd0);
      check("rst_cnt2", {16'd0, sent_count_2}, 32'd0);

      // Release, one-cycle latency then back-to-back words
      reset  = 1'b1;
      enable = 1'b1;
      tick();
      check("t1_valid", {30'd0, in_valid}, 32'd3);
      check("t1_data1_a", pipeline1_inputs, 32'h1);
      check("t1_data2_a", pipeline2_inputs, 32'h10000);
      check("t1_cnt1_a", {16'd0, sent_count_1}, 32'd0);
      tick();
      check("t1_data1_b", pipeline1_inputs, 32'h2);
      check("t1_data2_b", pipeline2_inputs, 32'h10001);
      check("t1_cnt1_b", {16'd0, sent_count_1}, 32'd1);
      tick();
      check("t1_data1_c", pipeline1_inputs, 32'h3);

      // Lane 1 stalled for five cycles, lane 2 keeps going
      stall_1 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t2_hold_data1", pipeline1_inputs, 32'h3);
         check("t2_hold_valid1", {31'd0, in_valid[0]}, 32'd1);
         check("t2_hold_cnt1", {16'd0, sent_count_1}, 32'd2);
      end
      check("t2_data2", pipeline2_inputs, 32'h10007);
      check("t2_cnt2", {16'd0, sent_count_2}, 32'd7);
      stall_1 = 1'b0;
      tick();
      check("t2_resume_data1", pipeline1_inputs, 32'h4);
      check("t2_resume_cnt1", {16'd0, sent_count_1}, 32'd3);

      // Fresh start, flush after the 16th accept
      reset = 1'b0;
      #2;
      reset = 1'b1;
      tick();
      check("t3_valid_start", {30'd0, in_valid}, 32'd3);
      repeat (15) tick();
      check("t3_cnt1_15", {16'd0, sent_count_1}, 32'd15);
      check("t3_noflush", {31'd0, flush_1}, 32'd0);
      tick();
      check("t3_flush1_a", {31'd0, flush_1}, 32'd1);
      check("t3_flush2_a", {31'd0, flush_2}, 32'd1);
      check("t3_valid_a", {30'd0, in_valid}, 32'd0);
      check("t3_data1_a", pipeline1_inputs, 32'd17);
      check("t3_cnt1_16", {16'd0, sent_count_1}, 32'd16);
      tick();
      check("t3_flush1_b", {31'd0, flush_1}, 32'd1);
      check("t3_valid_b", {30'd0, in_valid}, 32'd0);
      tick();
      check("t3_flush1_end", {31'd0, flush_1}, 32'd0);
      check("t3_valid_back", {30'd0, in_valid}, 32'd3);
      check("t3_data1_back", pipeline1_inputs, 32'd17);
      tick();
      check("t3_data1_next", pipeline1_inputs, 32'd18);
      check("t3_cnt1_next", {16'd0, sent_count_1}, 32'd17);

      // Stall raised during the second lane-1 flush
      repeat (15) tick();
      check("t4_flush1_a", {31'd0, flush_1}, 32'd1);
      check("t4_cnt1", {16'd0, sent_count_1}, 32'd32);
      check("t4_data1_a", pipeline1_inputs, 32'd33);
      stall_1 = 1'b1;
      tick();
      check("t4_flush1_b", {31'd0, flush_1}, 32'd1);
      check("t4_valid1_b", {31'd0, in_valid[0]}, 32'd0);
      tick();
      check("t4_flush1_end", {31'd0, flush_1}, 32'd0);
      check("t4_valid1_back", {31'd0, in_valid[0]}, 32'd1);
      check("t4_data1_back", pipeline1_inputs, 32'd33);
      tick();
      check("t4_held_data1", pipeline1_inputs, 32'd33);
      check("t4_held_cnt1", {16'd0, sent_count_1}, 32'd32);
      stall_1 = 1'b0;
      tick();
      check("t4_acc_data1", pipeline1_inputs, 32'd34);
      check("t4_acc_cnt1", {16'd0, sent_count_1}, 32'd33);
      check("t4_cnt2", {16'd0, sent_count_2}, 32'd34);

      // Enable dropped while lane 2 is stalled
      stall_2 = 1'b1;
      enable  = 1'b0;
      tick();
      check("t5_valid_a", {30'd0, in_valid}, 32'd2);
      check("t5_data2_a", pipeline2_inputs, 32'h10022);
      check("t5_cnt1_a", {16'd0, sent_count_1}, 32'd34);
      tick();
      check("t5_valid_b", {30'd0, in_valid}, 32'd2);
      check("t5_cnt2_b", {16'd0, sent_count_2}, 32'd34);
      stall_2 = 1'b0;
      tick();
      check("t5_valid_c", {30'd0, in_valid}, 32'd0);
      check("t5_cnt2_c", {16'd0, sent_count_2}, 32'd35);
      check("t5_data2_c", pipeline2_inputs, 32'h10023);
      tick();
      check("t5_valid_d", {30'd0, in_valid}, 32'd0);

      // Reset asserted with lane 1 mid-flush and lane 2 mid-stall
      reset = 1'b0;
      #2;
      reset   = 1'b1;
      enable  = 1'b1;
      stall_2 = 1'b1;
      tick();
      check("t6_valid_start", {30'd0, in_valid}, 32'd3);
      repeat (16) tick();
      check("t6_flush1_pre", {31'd0, flush_1}, 32'd1);
      check("t6_valid_pre", {30'd0, in_valid}, 32'd2);
      #2;
      reset = 1'b0;
      #1;
      check("t6_flush1", {31'd0, flush_1}, 32'd0);
      check("t6_valid", {30'd0, in_valid}, 32'd0);
      check("t6_data1", pipeline1_inputs, 32'h1);
      check("t6_data2", pipeline2_inputs, 32'h10000);
      check("t6_cnt1", {16'd0, sent_count_1}, 32'd0);
      check("t6_cnt2", {16'd0, sent_count_2}, 32'd0);

      // sent_count wrap from 16'hFFFF
      stall_1 = 1'b1;
      #1;
      reset = 1'b1;
      tick();
      check("t7_valid", {30'd0, in_valid}, 32'd3);
      force dut.u_lane1.count_q = 16'hFFFF;
      #1;
      release dut.u_lane1.count_q;
      check("t7_cnt1_forced", {16'd0, sent_count_1}, 32'h0000FFFF);
      stall_1 = 1'b0;
      tick();
      check("t7_cnt1_wrap", {16'd0, sent_count_1}, 32'd0);
      check("t7_data1", pipeline1_inputs, 32'h2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
